// File: rtl/dig_decode_sync_if.sv
// dig_decode_sync_if: digit scanner to seven-segment decoder signal bundle
interface dig_decode_sync_if;
    logic [3:0] x;
    logic       blank;
    logic       lamp_test;
    logic [6:0] dig;
    modport master (output x, blank, lamp_test, input dig);
    modport slave  (input x, blank, lamp_test, output dig);
endinterface

// File: rtl/dig_decode_sync.sv
// dig_decode_sync: registered hex-to-seven-segment decoder with blank, lamp test and selectable polarity
module dig_decode_sync #(
    parameter int ACTIVE_LOW = 1
) (
    input logic             clk,
    input logic             reset,
    dig_decode_sync_if.slave bus
);
    // Lit-segment map, element n is digit n, bits g..a
    localparam logic [15:0][6:0] SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };
    localparam logic [6:0] OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    logic [6:0] lit;
    logic [6:0] nxt;
    logic [6:0] dig_q;
    always_comb begin
        lit = bus.lamp_test ? 7'h7F : bus.blank ? 7'h00 : SEG[bus.x];
        nxt = (ACTIVE_LOW != 0) ? ~lit : lit;
    end
    always_ff @(posedge clk) dig_q <= reset ? OFF : nxt;
    assign bus.dig = dig_q;
endmodule

// File: tb/tb_dig_decode_sync.sv
// tb_dig_decode_sync: table, directed and randomized checks of both output polarities
module tb_dig_decode_sync;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    dig_decode_sync_if bal ();
    dig_decode_sync_if bah ();
    dig_decode_sync #(.ACTIVE_LOW(1)) dut_al (.clk(clk), .reset(reset), .bus(bal));
    dig_decode_sync #(.ACTIVE_LOW(0)) dut_ah (.clk(clk), .reset(reset), .bus(bah));
    typedef struct {
        logic [3:0] x;
        logic       b;
        logic       l;
        logic [6:0] eal;
        logic [6:0] eah;
    } vec_t;
    vec_t tv[$];
    // Segments lit for each digit, by letter
    string segs [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                         "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};
    function automatic logic [6:0] model(input logic [3:0] x, input logic b, input logic l,
                                         input logic r, input bit al);
        logic [6:0] on;
        string s;
        on = '0;
        s = segs[x];
        if (l) on = 7'h7F;
        else if (!b) for (int k = 0; k < s.len(); k++) on[int'(s[k]) - 97] = 1'b1;
        if (r) on = '0;
        return al ? ~on : on;
    endfunction
    task automatic drive(input logic [3:0] x, input logic b, input logic l, input logic r);
        bal.x = x; bal.blank = b; bal.lamp_test = l;
        bah.x = x; bah.blank = b; bah.lamp_test = l;
        reset = r;
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    initial begin
        logic [3:0] rx;
        logic rb, rl, rr;
        tv.push_back('{4'h0, 0, 0, 7'h40, 7'h3F});
        tv.push_back('{4'h1, 0, 0, 7'h79, 7'h06});
        tv.push_back('{4'h2, 0, 0, 7'h24, 7'h5B});
        tv.push_back('{4'h3, 0, 0, 7'h30, 7'h4F});
        tv.push_back('{4'h4, 0, 0, 7'h19, 7'h66});
        tv.push_back('{4'h5, 0, 0, 7'h12, 7'h6D});
        tv.push_back('{4'h6, 0, 0, 7'h02, 7'h7D});
        tv.push_back('{4'h7, 0, 0, 7'h78, 7'h07});
        tv.push_back('{4'h8, 0, 0, 7'h00, 7'h7F});
        tv.push_back('{4'h9, 0, 0, 7'h10, 7'h6F});
        tv.push_back('{4'hA, 0, 0, 7'h08, 7'h77});
        tv.push_back('{4'hB, 0, 0, 7'h03, 7'h7C});
        tv.push_back('{4'hC, 0, 0, 7'h46, 7'h39});
        tv.push_back('{4'hD, 0, 0, 7'h21, 7'h5E});
        tv.push_back('{4'hE, 0, 0, 7'h06, 7'h79});
        tv.push_back('{4'hF, 0, 0, 7'h0E, 7'h71});
        tv.push_back('{4'h5, 1, 0, 7'h7F, 7'h00});
        tv.push_back('{4'h5, 1, 1, 7'h00, 7'h7F});
        tv.push_back('{4'h5, 0, 0, 7'h12, 7'h6D});
        tv.push_back('{4'hA, 0, 1, 7'h00, 7'h7F});
        drive(4'h8, 0, 0, 1);
        step();
        step();
        check("reset_al", bal.dig, 7'h7F);
        check("reset_ah", bah.dig, 7'h00);
        drive(4'h8, 0, 0, 0);
        step();
        check("release_al", bal.dig, 7'h00);
        check("release_ah", bah.dig, 7'h7F);
        foreach (tv[i]) begin
            drive(tv[i].x, tv[i].b, tv[i].l, 0);
            step();
            check($sformatf("vec%0d_al", i), bal.dig, tv[i].eal);
            check($sformatf("vec%0d_ah", i), bah.dig, tv[i].eah);
        end
        drive(4'h3, 0, 0, 0);
        step();
        check("mid_x3", bal.dig, 7'h30);
        drive(4'h4, 0, 0, 1);
        step();
        check("mid_rst", bal.dig, 7'h7F);
        drive(4'h5, 0, 0, 0);
        step();
        check("mid_x5", bal.dig, 7'h12);
        drive(4'h2, 0, 0, 0);
        step();
        check("glitch_base", bal.dig, 7'h24);
        drive(4'h7, 0, 0, 0);
        #2;
        check("glitch_hold7", bal.dig, 7'h24);
        drive(4'h2, 0, 0, 0);
        step();
        check("glitch_back2", bal.dig, 7'h24);
        drive(4'h7, 0, 0, 0);
        #2;
        drive(4'h2, 0, 0, 0);
        #1;
        drive(4'h7, 0, 0, 0);
        step();
        check("glitch_end7", bal.dig, 7'h78);
        for (int i = 0; i < 300; i++) begin
            rx = 4'($urandom_range(0, 15));
            rb = ($urandom_range(0, 3) == 0);
            rl = ($urandom_range(0, 5) == 0);
            rr = ($urandom_range(0, 11) == 0);
            drive(rx, rb, rl, rr);
            step();
            check($sformatf("rand%0d_al", i), bal.dig, model(rx, rb, rl, rr, 1'b1));
            check($sformatf("rand%0d_ah", i), bah.dig, model(rx, rb, rl, rr, 1'b0));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dig_decode_sync.md
Name: dig_decode_sync

Overview:
Hex-digit to seven-segment decoder for the board's multiplexed display path. It converts a 4-bit nibble (0-F) into a 7-bit segment pattern and registers the result, so the pattern appears one clock after the input is sampled. The peripheral's digit scanner drives it, and its output goes directly to the segment pins (digi[6:0]).

Parameters:
ACTIVE_LOW, 1, 1 = segment lit when its bit is 0 (common-anode board); 0 = lit when its bit is 1.

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
x  input  4  hex nibble to display (0x0-0xF)
blank  input  1  1 = all segments off, regardless of x
lamp_test  input  1  1 = all segments lit; has priority over blank and x
dig  output  7  registered segment pattern; bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g

Behaviour:
- Clocking and latency
  - Single clock domain; no combinational path from the inputs to dig.
  - dig on cycle n+1 reflects x/blank/lamp_test sampled at the rising edge of cycle n. Latency is exactly 1 clock.
  - A new pattern is accepted every cycle; there is no enable or handshake.
- Reset
  - While reset=1 at a rising edge, dig loads the all-off pattern: 7'h7F when ACTIVE_LOW=1, 7'h00 when ACTIVE_LOW=0.
  - Reset overrides every other input.
  - The first decoded value appears on the first edge after reset is released.
- Priority: reset > lamp_test > blank > decode of x.
- Logical lit-segment map (1 = lit, order g..a):
  - 0:0111111, 1:0000110, 2:1011011, 3:1001111
  - 4:1100110, 5:1101101, 6:1111101, 7:0000111
  - 8:1111111, 9:1101111, A:1110111, b:1111100
  - C:0111001, d:1011110, E:1111001, F:1110001
- Output polarity
  - ACTIVE_LOW=1: dig = bitwise inverse of the map. Examples: 0 -> 7'h40, 1 -> 7'h79, 8 -> 7'h00, F -> 7'h0E.
  - ACTIVE_LOW=0: dig = the map as written.
- Lamp test: all seven segments lit (7'h00 when ACTIVE_LOW=1, 7'h7F when ACTIVE_LOW=0).
- Blank: all-off pattern, identical to the reset value.
- Every 4-bit code is defined, so there is no illegal input. X/Z on x must not be treated as a valid code; simulation behaviour for X/Z is don't-care.
- Simultaneous events
  - lamp_test and blank both high -> lamp test wins.
  - Input changes between clock edges are invisible at dig until the next edge.
- Mid-stream reset: asserting reset for one cycle forces all-off on that edge. Decoding resumes from the current x on the next edge after release.
- No other state is kept; the block is a purely registered decoder.

Test Plan:
- Reset: hold reset=1 for 2 cycles with x=8 -> dig=7'h7F. Release reset -> one edge later dig=7'h00.
- Full sweep, ACTIVE_LOW=1: x = 0..F, one value per cycle -> dig sequence 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E, each lagging its x by exactly 1 cycle.
- Polarity, ACTIVE_LOW=0: x=0 -> 7'h3F; x=1 -> 7'h06; x=A -> 7'h77.
- Priority: x=5, blank=1 -> dig=7'h7F. Then lamp_test=1 with blank still 1 -> 7'h00. Drop both -> 7'h12.
- Mid-stream reset: streaming x=3,4,5 with reset pulsed on the edge carrying x=4 -> outputs 30,7F,12.
- Glitch: toggle x between edges (2 -> 7 -> 2 within one cycle) -> dig changes only at the clock edge, to the value sampled there.
